// File: rtl/serial_sub_full_sub.sv
// Full-subtract cell for the bit-serial subtractor.
// It is built from two half subtractors. The borrows from the two stages
// are ORed together to form the cell's borrow out.

module half_sub (
  input  logic i_x,
  input  logic i_y,
  output logic o_d,
  output logic o_b
);

  assign o_d = i_x ^ i_y;
  assign o_b = ~i_x & i_y;

endmodule

module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_d1;
  logic w_b1;
  logic w_b2;

  half_sub u_hs0 (
    .i_x (a),
    .i_y (b),
    .o_d (w_d1),
    .o_b (w_b1)
  );

  half_sub u_hs1 (
    .i_x (w_d1),
    .i_y (bin),
    .o_d (d),
    .o_b (w_b2)
  );

  assign bout = w_b1 | w_b2;

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor. It computes (a - b) mod 2^WIDTH one bit per clock,
// starting with the LSB.
// The operands are latched on the accept edge. The result is then built up
// over WIDTH RUN edges and held in DONE until the consumer takes it.
//
// state | meaning
// IDLE  | waiting for an operand pair (in_ready = 1)
// RUN   | processing one bit per edge, LSB first
// DONE  | result valid, held until out_ready

module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             brow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_diff;
  logic [WIDTH-1:0] w_diff_shift;
  logic             r_borrow;
  logic             r_brow;
  logic [CW-1:0]    r_cnt;
  logic             w_d;
  logic             w_bout;
  logic             w_accept;
  logic             w_last;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_last   = (r_cnt == LAST_CNT);

  full_sub u_full_sub (
    .a    (r_a_sr[0]),
    .b    (r_b_sr[0]),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bout)
  );

  // Next-state decode: accept, finish after the last bit, release on handshake.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Shift diff right and place the new bit at the MSB.
  // Written this way so that it also works when WIDTH is 1.
  always_comb begin
    w_diff_shift = r_diff >> 1;
    w_diff_shift[WIDTH-1] = w_d;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Datapath: load on accept, then do one full-subtract step per RUN edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_brow   <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a_sr   <= a;
      r_b_sr   <= b;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else if (r_state == RUN) begin
      r_a_sr   <= r_a_sr >> 1;
      r_b_sr   <= r_b_sr >> 1;
      r_diff   <= w_diff_shift;
      r_borrow <= w_bout;
      r_cnt    <= r_cnt + CW'(1);
      if (w_last) r_brow <= w_bout;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign diff      = r_diff;
  assign brow      = r_brow;

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial subtractor that computes a − b for two WIDTH-bit operands, one bit per clock, LSB first.
- Each cycle evaluates one full-subtract cell (two half-subtractor stages plus borrow OR) against a registered borrow.
- Sits downstream of operand-producing logic; its result feeds arithmetic/compare consumers.
- Valid/ready handshakes on both the operand input and the result output.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range ≥ 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair a/b is valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  minuend; sampled only on the accept edge.
- b  input  WIDTH  subtrahend; sampled only on the accept edge.
- out_valid  output  1  diff/brow hold a completed result.
- out_ready  input  1  consumer takes the result.
- diff  output  WIDTH  (a − b) mod 2^WIDTH.
- brow  output  1  final borrow; 1 iff a < b unsigned.

Behaviour:
- Reset (async, rst=1): state=IDLE; in_ready=1; out_valid=0; diff=0; brow=0; operand shift registers=0; bit counter=0; borrow register=0.
- FSM states and transitions:
  - IDLE → RUN on an edge with in_valid && in_ready.
  - RUN → DONE on the edge that processes bit WIDTH−1.
  - DONE → IDLE on an edge with out_valid && out_ready.
- Accept edge (IDLE): latch a and b into shift registers; clear borrow register, bit counter and diff.
- RUN, each edge processes bit i (i = 0..WIDTH−1):
  - x = a_sr[0], y = b_sr[0], bin = borrow register.
  - d = x^y^bin; bout = (~x & y) | (~(x^y) & bin).
  - a_sr and b_sr shift right one bit.
  - diff shifts right with d inserted at MSB; borrow register ← bout; counter increments.
  - After WIDTH shifts, diff[i] = bit i of the result.
- On the edge processing bit WIDTH−1: brow ← bout; state → DONE.
- Latency: if operands are accepted at edge T, out_valid rises after edge T+WIDTH. No overlap, so throughput is one operation per WIDTH+2 cycles minimum (accept, WIDTH RUN edges, handoff).
- in_ready = (state==IDLE); out_valid = (state==DONE); both are decoded from registered state.
- DONE holds diff/brow stable for as long as out_ready=0 (backpressure, unbounded).
- in_valid during RUN/DONE: ignored; a/b changes outside the accept edge have no effect.
- diff/brow during RUN: intermediate values, undefined to consumers; qualify with out_valid only.
- Counter width: $clog2(WIDTH+1); WIDTH=1 gives exactly one RUN cycle.
- rst mid-RUN or mid-DONE: immediate return to the reset state; the partial result is discarded and no out_valid pulse occurs.
- Equal operands: diff=0, brow=0. a=0, b=2^WIDTH−1: diff=1, brow=1.

Decomposition:
- No shared package. State encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) are localparams inside serial_sub.
- One sub-module: full_sub (inputs a, b, bin; outputs d, bout), built from two half-subtractor instances plus OR of their borrows. serial_sub instantiates one full_sub for the per-bit datapath.

Test Plan:
- WIDTH=8, a=0x5A, b=0x23, out_ready=1 → out_valid rises 8 cycles after accept; diff=0x37, brow=0; in_ready returns 1 the next cycle.
- a=0x10, b=0x20 → diff=0xF0, brow=1. a=0x00, b=0xFF → diff=0x01, brow=1. a=b=0xA5 → diff=0x00, brow=0.
- Backpressure: out_ready=0 for 5 cycles after out_valid → diff/brow/out_valid stable; in_ready=0 throughout. Raising out_ready → IDLE next edge.
- Assert in_valid with new operands during RUN; change a/b mid-RUN → ignored; result matches the originally accepted pair.
- Pulse rst at the 4th RUN cycle → all outputs 0, in_ready=1 immediately; no out_valid. A following op 0x03−0x01 → diff=0x02, brow=0.
- Random regression, WIDTH∈{1,8,16}, ≥1000 ops with random handshake stalls → diff == (a−b) mod 2^WIDTH and brow == (a<b) for every op.
